// File: rtl/elevator_pkg.sv
// ============================================================================
// elevator_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the N-floor elevator controller:
//   - state_t    : 4-bit controller state, its codes go straight to the
//                  BCD/7-segment display (IDLE=0, MOVE=1, DOOR=2, CLOSE=3)
//   - MAX_FLOORS : largest floor count the controller supports
//   - SEC_W      : width of the seconds limit handed to sec_timer
// ============================================================================
package elevator_pkg;

    localparam int MAX_FLOORS = 16;
    localparam int SEC_W      = 8;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        MOVE  = 4'd1,
        DOOR  = 4'd2,
        CLOSE = 4'd3
    } state_t;

endpackage

// File: rtl/elevator_ctrl_n_sec_timer.sv
// ============================================================================
// sec_timer
// ----------------------------------------------------------------------------
// One-second timebase plus a seconds counter. A prescaler counts
// 0..CLK_HZ-1 and emits a tick; the ticks are counted in seconds.
// 'done' is high during the last clock cycle of a limit_s-second interval.
// That lets the caller change state on the edge that completes the interval,
// so an N-second state lasts exactly N*CLK_HZ cycles.
//
// Ports:
//   sys_clk  in  1      : clock, rising edge
//   sys_rst  in  1      : asynchronous active-high reset
//   clear    in  1      : restart the interval (both counters to zero)
//   limit_s  in  SEC_W  : interval length in seconds
//   done     out 1      : last cycle of the interval
// ============================================================================
module sec_timer
    import elevator_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clear,
    input  logic [SEC_W-1:0] limit_s,
    output logic             done
);

    localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0]    r_pre;
    logic [SEC_W-1:0] r_sec;
    logic             w_tick;

    assign w_tick = (r_pre == PRE_LAST);

    // 'done' must not depend on 'clear'. The controller derives 'clear' from
    // its next state, and that next state depends on 'done'.
    assign done = w_tick && ((r_sec + SEC_W'(1)) == limit_s);

    // Prescaler and seconds counter. Clear has priority so that each state
    // entry starts a fresh interval.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (clear) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_sec <= r_sec + SEC_W'(1);
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

endmodule

// File: rtl/elevator_ctrl_n.sv
// ============================================================================
// elevator_ctrl_n
// ----------------------------------------------------------------------------
// N-floor elevator controller. Hall/car calls are latched into a pending
// bitmap and served in SCAN order: the car keeps its direction while calls
// remain ahead and reverses otherwise. Travel and door times come from one
// shared sec_timer instance.
//
// Optional feature macro: ELEV_DOOR_REOPEN_EN
//   defined   : a call to the current floor during CLOSE reopens the door
//               (back to DOOR, full door time, bit not set)
//   undefined : that call sets the pending bit. It is served from IDLE once
//               CLOSE completes.
//
// Ports:
//   sys_clk       in  1      : clock, rising edge
//   sys_rst       in  1      : asynchronous active-high reset
//   valid         in  1      : call strobe
//   call_floor    in  FW     : requested floor (ignored if >= FLOORS)
//   current_floor out FW     : floor the car is at or last passed
//   door_open     out 1      : high in DOOR and CLOSE
//   moving        out 1      : high in MOVE
//   dir_up        out 1      : SCAN direction
//   pending       out FLOORS : outstanding call bitmap
//   state         out 4      : state code for the display
// ============================================================================
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int FLOORS  = 8,
    parameter int CLK_HZ  = 50_000_000,
    parameter int MOVE_S  = 2,
    parameter int DOOR_S  = 4,
    parameter int CLOSE_S = 1,
    parameter int FW      = $clog2(FLOORS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              valid,
    input  logic [FW-1:0]     call_floor,
    output logic [FW-1:0]     current_floor,
    output logic              door_open,
    output logic              moving,
    output logic              dir_up,
    output logic [FLOORS-1:0] pending,
    output logic [3:0]        state
);

    localparam logic [FW:0] FLOORS_W = (FW + 1)'(FLOORS);

    state_t            r_state, w_nextState;
    logic [FW-1:0]     r_floor, w_nextFloor, w_stepFloor;
    logic              r_dirUp, w_nextDir;
    logic              r_doorOpen, r_moving;
    logic [FLOORS-1:0] r_pending, w_pendIn, w_setMask, w_clrMask;
    logic [FLOORS-1:0] w_curBit, w_stepBit;
    logic              w_callOk, w_absorb, w_restart;
    logic              w_timerClr, w_timerDone;
    logic [SEC_W-1:0]  w_limit;

    // Bits of floors strictly above (up=1) or strictly below (up=0) floor f.
    // Because a call exists ahead before the car moves, it never steps past
    // floor 0 or FLOORS-1.
    function automatic logic [FLOORS-1:0] aheadMask(input logic [FW-1:0] f,
                                                    input logic          up);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) begin
            m[i] = up ? (i > int'(f)) : (i < int'(f));
        end
        return m;
    endfunction

    // A call at the current floor is swallowed while the door is already open.
    // With reopen enabled this also covers CLOSE, which goes back to DOOR.
    assign w_callOk = valid && ({1'b0, call_floor} < FLOORS_W);
`ifdef ELEV_DOOR_REOPEN_EN
    assign w_absorb = (call_floor == r_floor) && ((r_state == DOOR) || (r_state == CLOSE));
`else
    assign w_absorb = (call_floor == r_floor) && (r_state == DOOR);
`endif
    assign w_setMask   = (w_callOk && !w_absorb) ? (FLOORS'(1) << call_floor) : '0;
    assign w_pendIn    = r_pending | w_setMask;
    assign w_curBit    = FLOORS'(1) << r_floor;
    assign w_stepFloor = r_dirUp ? (r_floor + FW'(1)) : (r_floor - FW'(1));
    assign w_stepBit   = FLOORS'(1) << w_stepFloor;

    // Interval length for the state we are currently in.
    always_comb begin
        w_limit = '0;
        case (r_state)
            MOVE:    w_limit = SEC_W'(MOVE_S);
            DOOR:    w_limit = SEC_W'(DOOR_S);
            CLOSE:   w_limit = SEC_W'(CLOSE_S);
            default: w_limit = '0;
        endcase
    end

    // Next-state logic. IDLE decides on the registered bitmap, so a call
    // moves the car one edge after it was latched. A MOVE step also sees a
    // call arriving on the same edge, so the car can stop there and clear it.
    always_comb begin
        w_nextState = r_state;
        w_nextFloor = r_floor;
        w_nextDir   = r_dirUp;
        w_clrMask   = '0;
        w_restart   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|(r_pending & w_curBit)) begin
                    w_nextState = DOOR;
                    w_clrMask   = w_curBit;
                end else if (|(r_pending & aheadMask(r_floor, r_dirUp))) begin
                    w_nextState = MOVE;
                end else if (|r_pending) begin
                    w_nextDir   = !r_dirUp;
                    w_nextState = MOVE;
                end
            end
            MOVE: begin
                if (w_timerDone) begin
                    w_nextFloor = w_stepFloor;
                    if (|(w_pendIn & w_stepBit)) begin
                        w_nextState = DOOR;
                        w_clrMask   = w_stepBit;
                    end else if (|(w_pendIn & aheadMask(w_stepFloor, r_dirUp))) begin
                        w_restart = 1'b1;
                    end else if (|w_pendIn) begin
                        w_nextDir = !r_dirUp;
                        w_restart = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            DOOR: begin
                if (w_timerDone) begin
                    w_nextState = CLOSE;
                end
            end
            CLOSE: begin
`ifdef ELEV_DOOR_REOPEN_EN
                if (valid && (call_floor == r_floor)) begin
                    w_nextState = DOOR;
                end else if (w_timerDone) begin
                    w_nextState = IDLE;
                end
`else
                if (w_timerDone) begin
                    w_nextState = IDLE;
                end
`endif
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_timerClr = (w_nextState != r_state) || w_restart;

    sec_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (w_timerClr),
        .limit_s (w_limit),
        .done    (w_timerDone)
    );

    // State register and registered outputs. The clear mask is applied after
    // the set mask, so a same-edge set and clear of one floor counts as served.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_floor    <= '0;
            r_dirUp    <= 1'b1;
            r_pending  <= '0;
            r_doorOpen <= 1'b0;
            r_moving   <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_floor    <= w_nextFloor;
            r_dirUp    <= w_nextDir;
            r_pending  <= w_pendIn & ~w_clrMask;
            r_doorOpen <= (w_nextState == DOOR) || (w_nextState == CLOSE);
            r_moving   <= (w_nextState == MOVE);
        end
    end

    assign current_floor = r_floor;
    assign door_open     = r_doorOpen;
    assign moving        = r_moving;
    assign dir_up        = r_dirUp;
    assign pending       = r_pending;
    assign state         = r_state;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// ============================================================================
// tb_elevator_ctrl_n
// ----------------------------------------------------------------------------
// Directed bench for elevator_ctrl_n with FLOORS=8, CLK_HZ=4, MOVE_S=2,
// DOOR_S=4 and CLOSE_S=1. At these settings a move step takes 8 cycles,
// DOOR takes 16 and CLOSE takes 4. A second instance with FLOORS=6 accepts
// out-of-range floor codes.
// ============================================================================
module tb_elevator_ctrl_n;

    localparam int FLOORS  = 8;
    localparam int CLK_HZ  = 4;
    localparam int MOVE_S  = 2;
    localparam int DOOR_S  = 4;
    localparam int CLOSE_S = 1;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_MOVE  = 4'd1;
    localparam logic [3:0] S_DOOR  = 4'd2;
    localparam logic [3:0] S_CLOSE = 4'd3;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       valid = 1'b0;
    logic [2:0] call_floor = 3'd0;
    logic [2:0] current_floor;
    logic       door_open, moving, dir_up;
    logic [7:0] pending;
    logic [3:0] state;

    logic       valid2 = 1'b0;
    logic [2:0] call2 = 3'd0;
    logic [2:0] floor2;
    logic       door2, moving2, dir2;
    logic [5:0] pending2;
    logic [3:0] state2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [2:0] f;
        int         adv;
        logic [2:0] eFloor;
        logic       eDoor;
        logic       eMov;
        logic       eDir;
        logic [7:0] ePend;
        logic [3:0] eState;
    } vec_t;

    vec_t vecs[$];

    always #5 sys_clk = ~sys_clk;

    elevator_ctrl_n #(
        .FLOORS (FLOORS), .CLK_HZ (CLK_HZ), .MOVE_S (MOVE_S),
        .DOOR_S (DOOR_S), .CLOSE_S (CLOSE_S)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .valid         (valid),
        .call_floor    (call_floor),
        .current_floor (current_floor),
        .door_open     (door_open),
        .moving        (moving),
        .dir_up        (dir_up),
        .pending       (pending),
        .state         (state)
    );

    elevator_ctrl_n #(
        .FLOORS (6), .CLK_HZ (CLK_HZ), .MOVE_S (MOVE_S),
        .DOOR_S (DOOR_S), .CLOSE_S (CLOSE_S)
    ) dut6 (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .valid         (valid2),
        .call_floor    (call2),
        .current_floor (floor2),
        .door_open     (door2),
        .moving        (moving2),
        .dir_up        (dir2),
        .pending       (pending2),
        .state         (state2)
    );

    task automatic addVec(input logic v, input logic [2:0] f, input int adv,
                          input logic [2:0] ef, input logic ed, input logic em,
                          input logic eu, input logic [7:0] ep, input logic [3:0] es);
        vec_t x;
        x.v = v; x.f = f; x.adv = adv;
        x.eFloor = ef; x.eDoor = ed; x.eMov = em; x.eDir = eu;
        x.ePend = ep; x.eState = es;
        vecs.push_back(x);
    endtask

    // Drive a call for one edge, let 'adv' rising edges pass in total, and
    // return on the following falling edge, ready to sample.
    task automatic applyStimulus(input logic v, input logic [2:0] f, input int adv);
        valid      = v;
        call_floor = f;
        @(posedge sys_clk);
        #1;
        valid = 1'b0;
        repeat (adv - 1) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic checkOutput(input string name, input logic [2:0] f, input logic d,
                               input logic m, input logic u, input logic [7:0] p,
                               input logic [3:0] s);
        checks++;
        if ({current_floor, door_open, moving, dir_up, pending, state} !== {f, d, m, u, p, s}) begin
            errors++;
            $display("[TB] FAIL %s: got floor=%0d door=%0b moving=%0b dir_up=%0b pending=%h state=%0d, expected floor=%0d door=%0b moving=%0b dir_up=%0b pending=%h state=%0d",
                     name, current_floor, door_open, moving, dir_up, pending, state,
                     f, d, m, u, p, s);
        end
    endtask

    initial begin
        // Scenario: call 3 from floor 0, full trip and door cycle.
        addVec(1, 3, 1,  0, 0, 0, 1, 8'h08, S_IDLE);
        addVec(0, 0, 1,  0, 0, 1, 1, 8'h08, S_MOVE);
        addVec(0, 0, 7,  0, 0, 1, 1, 8'h08, S_MOVE);
        addVec(0, 0, 1,  1, 0, 1, 1, 8'h08, S_MOVE);
        addVec(0, 0, 8,  2, 0, 1, 1, 8'h08, S_MOVE);
        addVec(0, 0, 7,  2, 0, 1, 1, 8'h08, S_MOVE);
        addVec(0, 0, 1,  3, 1, 0, 1, 8'h00, S_DOOR);
        addVec(0, 0, 15, 3, 1, 0, 1, 8'h00, S_DOOR);
        addVec(0, 0, 1,  3, 1, 0, 1, 8'h00, S_CLOSE);
        addVec(0, 0, 3,  3, 1, 0, 1, 8'h00, S_CLOSE);
        addVec(0, 0, 1,  3, 0, 0, 1, 8'h00, S_IDLE);
        // Scenario: SCAN with calls {6,1} from floor 3 going up.
        addVec(1, 6, 1,  3, 0, 0, 1, 8'h40, S_IDLE);
        addVec(1, 1, 1,  3, 0, 1, 1, 8'h42, S_MOVE);
        addVec(0, 0, 8,  4, 0, 1, 1, 8'h42, S_MOVE);
        addVec(0, 0, 8,  5, 0, 1, 1, 8'h42, S_MOVE);
        addVec(0, 0, 8,  6, 1, 0, 1, 8'h02, S_DOOR);
        addVec(0, 0, 20, 6, 0, 0, 1, 8'h02, S_IDLE);
        addVec(0, 0, 1,  6, 0, 1, 0, 8'h02, S_MOVE);
        addVec(0, 0, 8,  5, 0, 1, 0, 8'h02, S_MOVE);
        addVec(0, 0, 32, 1, 1, 0, 0, 8'h00, S_DOOR);
        addVec(0, 0, 20, 1, 0, 0, 0, 8'h00, S_IDLE);

        #1 sys_rst = 1'b1;
        #3 checkOutput("reset_state", 0, 0, 0, 1, 8'h00, S_IDLE);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;

        // Call at the current floor from IDLE, plus a call absorbed in DOOR.
        applyStimulus(1, 0, 1);  checkOutput("s2_bit_set",     0, 0, 0, 1, 8'h01, S_IDLE);
        applyStimulus(0, 0, 1);  checkOutput("s2_door",        0, 1, 0, 1, 8'h00, S_DOOR);
        applyStimulus(0, 0, 2);  checkOutput("s2_door_hold",   0, 1, 0, 1, 8'h00, S_DOOR);
        applyStimulus(1, 0, 1);  checkOutput("s2_absorbed",    0, 1, 0, 1, 8'h00, S_DOOR);
        applyStimulus(0, 0, 13); checkOutput("s2_close",       0, 1, 0, 1, 8'h00, S_CLOSE);
        applyStimulus(0, 0, 3);  checkOutput("s2_close_last",  0, 1, 0, 1, 8'h00, S_CLOSE);
        applyStimulus(0, 0, 1);  checkOutput("s2_idle",        0, 0, 0, 1, 8'h00, S_IDLE);

        // Call at the current floor during CLOSE.
        applyStimulus(1, 0, 1);  checkOutput("s6_bit_set",     0, 0, 0, 1, 8'h01, S_IDLE);
        applyStimulus(0, 0, 17); checkOutput("s6_close",       0, 1, 0, 1, 8'h00, S_CLOSE);
`ifdef ELEV_DOOR_REOPEN_EN
        applyStimulus(1, 0, 1);  checkOutput("s6_reopen",      0, 1, 0, 1, 8'h00, S_DOOR);
        applyStimulus(0, 0, 15); checkOutput("s6_door_hold",   0, 1, 0, 1, 8'h00, S_DOOR);
        applyStimulus(0, 0, 1);  checkOutput("s6_close2",      0, 1, 0, 1, 8'h00, S_CLOSE);
        applyStimulus(0, 0, 4);  checkOutput("s6_idle",        0, 0, 0, 1, 8'h00, S_IDLE);
`else
        applyStimulus(1, 0, 1);  checkOutput("s6_bit_in_close", 0, 1, 0, 1, 8'h01, S_CLOSE);
        applyStimulus(0, 0, 3);  checkOutput("s6_idle_pending", 0, 0, 0, 1, 8'h01, S_IDLE);
        applyStimulus(0, 0, 1);  checkOutput("s6_redoor",       0, 1, 0, 1, 8'h00, S_DOOR);
        applyStimulus(0, 0, 20); checkOutput("s6_idle",         0, 0, 0, 1, 8'h00, S_IDLE);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].f, vecs[i].adv);
            checkOutput($sformatf("vec%0d", i), vecs[i].eFloor, vecs[i].eDoor, vecs[i].eMov,
                        vecs[i].eDir, vecs[i].ePend, vecs[i].eState);
        end

        // Reset while moving at floor 2.
        applyStimulus(1, 4, 1);  checkOutput("s5_bit_set",     1, 0, 0, 0, 8'h10, S_IDLE);
        applyStimulus(0, 0, 1);  checkOutput("s5_reverse",     1, 0, 1, 1, 8'h10, S_MOVE);
        applyStimulus(0, 0, 8);  checkOutput("s5_floor2",      2, 0, 1, 1, 8'h10, S_MOVE);
        applyStimulus(0, 0, 2);
        sys_rst = 1'b1;
        #1 checkOutput("s5_async_reset", 0, 0, 0, 1, 8'h00, S_IDLE);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        applyStimulus(0, 0, 20); checkOutput("s5_no_motion",   0, 0, 0, 1, 8'h00, S_IDLE);

        // Out-of-range floor codes on the 6-floor instance.
        valid2 = 1'b1;
        call2  = 3'd7;
        @(posedge sys_clk);
        #1 call2 = 3'd6;
        @(posedge sys_clk);
        #1 valid2 = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({pending2, state2, floor2, moving2} !== {6'b000000, S_IDLE, 3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL oor_ignored: got pending=%b state=%0d floor=%0d moving=%0b, expected pending=000000 state=0 floor=0 moving=0",
                     pending2, state2, floor2, moving2);
        end
        valid2 = 1'b1;
        call2  = 3'd5;
        @(posedge sys_clk);
        #1 valid2 = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({pending2, state2} !== {6'b100000, S_IDLE}) begin
            errors++;
            $display("[TB] FAIL top_floor_call: got pending=%b state=%0d, expected pending=100000 state=0",
                     pending2, state2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_n.md
# elevator_ctrl_n

Parametrised N-floor elevator controller. Queues hall/car calls in a pending-call bitmap and serves them in SCAN order: it keeps its direction while calls remain ahead, otherwise it reverses. Door and travel delays come from an internal one-second timebase, so no external pulse generator or reset handshakes are needed. It sits between the switch/valid input debouncing and the LCD/7-segment display blocks, and drives them with floor, door, direction and state.

## Interface
Parameters:
- FLOORS, 8: number of floors, 2..16.
- CLK_HZ, 50_000_000: sys_clk cycles per second.
- MOVE_S, 2: seconds to travel one floor.
- DOOR_S, 4: seconds the door stays open.
- CLOSE_S, 1: seconds for the door-closing phase.
- FW, $clog2(FLOORS): floor index width (derived).

Ports:
- sys_clk in 1: the single clock; all logic is on its rising edge.
- sys_rst in 1: asynchronous, active-high reset.
- valid in 1: call strobe, sampled every cycle.
- call_floor in FW: requested floor, qualified by valid.
- current_floor out FW: floor the car is at or last passed.
- door_open out 1: 1 while in DOOR or CLOSE.
- moving out 1: 1 while in MOVE.
- dir_up out 1: current SCAN direction.
- pending out FLOORS: outstanding call bitmap.
- state out 4: state code for BCD display.

## Operation
- Reset values: current_floor=0, door_open=0, moving=0, dir_up=1, pending=0, state=IDLE, timers=0.
- Call capture:
  - If valid and call_floor<FLOORS, set pending[call_floor].
  - Out-of-range calls are ignored.
  - A call for a floor that is already pending is a no-op.
- States and codes: IDLE=0, MOVE=1, DOOR=2, CLOSE=3.
- IDLE:
  - If pending[current_floor]=1: go to DOOR and clear that bit.
  - Else if any call is ahead in dir_up: go to MOVE.
  - Else if any call is behind: toggle dir_up and go to MOVE.
  - Else stay in IDLE.
- MOVE:
  - On timer expiry (MOVE_S s), current_floor steps by ±1.
  - If the new floor is pending: go to DOOR and clear its bit.
  - Otherwise stay in MOVE and restart the timer.
  - The car never steps past floor 0 or FLOORS-1. If no call is ahead at a step, re-evaluate as in IDLE on the same edge: reverse, or return to IDLE.
- DOOR: hold DOOR_S s, then go to CLOSE.
- CLOSE: hold CLOSE_S s, then go to IDLE.
- A call to current_floor while in DOOR is absorbed: the bit is not set and the timer is not extended.
- Same-edge set and clear of the same floor bit: the clear wins, and the floor counts as served.

## Timing
- Timer:
  - A prescaler counts 0..CLK_HZ-1 and emits a 1 s tick.
  - A seconds counter counts the ticks.
  - Both are cleared on every state entry, so a state lasting N s lasts exactly N*CLK_HZ cycles.
- valid sampled at edge k: pending bit is visible after edge k.
- IDLE reacts at edge k+1: moving=1, or door_open=1, after edge k+1.
- MOVE entered at edge t: floor changes at edge t+MOVE_S*CLK_HZ.
- DOOR is entered on that same edge when the floor is pending.
- Outputs are all registered; there is no combinational path from input to output.
- Reset asserted mid-operation aborts immediately to the reset values. Pending calls are lost.

## Configuration
- ELEV_DOOR_REOPEN_EN defined:
  - A call to current_floor during CLOSE returns to DOOR on the next edge.
  - The DOOR_S timer restarts and the bit is not set.
- ELEV_DOOR_REOPEN_EN undefined:
  - Such a call sets the pending bit.
  - The pending bit is served from IDLE after CLOSE completes, which reopens the door.

## Structure
- Package elevator_pkg holds:
  - State codes IDLE/MOVE/DOOR/CLOSE as a 4-bit enum or localparams.
  - The maximum FLOORS constant.
- Sub-module sec_timer(CLK_HZ):
  - Inputs: sys_clk, sys_rst, clear, limit_s.
  - Output: a done pulse.
  - One instance, shared across states.
- SCAN "call ahead/behind" uses mask compares on pending versus current_floor, kept inside the top level.

## Test plan
Conditions for all scenarios: FLOORS=8, CLK_HZ=4, MOVE_S=2, DOOR_S=4, CLOSE_S=1.
1. Reset, then call 3 at cycle 0 -> moving=1 at cycle 2. Floor reaches 1/2/3 at cycles 10/18/26, door_open 26..45, state=IDLE at 46, pending=0.
2. While at floor 0 in IDLE, call 0 -> DOOR one cycle after the bit sets, no movement, door_open for 20 cycles.
3. At floor 4 moving up with pending {6,1} -> stops at 6 first, then dir_up=0 and travels to 1. Floor 5 is never opened.
4. call_floor=9 with valid -> pending unchanged, state stays IDLE.
5. Assert sys_rst mid-MOVE at floor 2 -> all outputs at their reset values immediately; no motion afterwards.
6. Call the current floor during CLOSE -> with ELEV_DOOR_REOPEN_EN, DOOR re-entered the next cycle. Without it, the bit sets and the door reopens one cycle after IDLE.
